// File: rtl/alu_byte_seq.sv
// Byte-serial sequencer that runs a wide operation through an external 8-bit ALU,
// chaining the carry from byte to byte and assembling the wide result.
module alu_byte_seq #(
  parameter int unsigned MAX_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [8*MAX_BYTES-1:0] req_a,
  input  logic [8*MAX_BYTES-1:0] req_b,
  input  logic [2:0]             req_oper,
  input  logic                   req_c_in,
  input  logic [1:0]             req_len,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic                   alu_c_in,
  output logic [2:0]             alu_oper,
  input  logic [7:0]             alu_sum,
  input  logic                   alu_c_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [8*MAX_BYTES-1:0] res_sum,
  output logic                   res_c_out
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [8*MAX_BYTES-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [2:0]             oper_q, oper_d;
  logic                   cin_q, cin_d, carry_q, carry_d;
  logic [1:0]             len_q, len_d, k_q, k_d;
  logic [4:0]             bit_base;

  assign bit_base  = {k_q, 3'b000};
  assign res_sum   = sum_q;
  assign res_c_out = carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      oper_q  <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      len_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      oper_q  <= oper_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      len_q   <= len_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    oper_d    = oper_q;
    cin_d     = cin_q;
    carry_d   = carry_q;
    len_d     = len_q;
    k_d       = k_q;
    req_ready = 1'b0;
    res_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_c_in  = 1'b0;
    alu_oper  = '0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          oper_d  = req_oper;
          cin_d   = req_c_in;
          len_d   = req_len;
          k_d     = '0;
          sum_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        alu_a    = a_q[bit_base +: 8];
        alu_b    = b_q[bit_base +: 8];
        alu_oper = oper_q;
        // Byte 0 takes the requester's carry; later bytes chain the previous carry out.
        alu_c_in = (k_q == 2'd0) ? cin_q : carry_q;
        sum_d[bit_base +: 8] = alu_sum;
        carry_d  = alu_c_out;
        k_d      = k_q + 2'd1;
        if (k_q == len_q) state_d = StDone;
      end
      StDone: begin
        res_valid = 1'b1;
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_alu_byte_seq.sv
// Bench for alu_byte_seq: an adder stands in for the ALU, and results are predicted
// by plain wide addition over the selected number of bytes.
module tb_alu_byte_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [2:0]  req_oper;
  logic        req_c_in;
  logic [1:0]  req_len;
  logic [7:0]  alu_a, alu_b, alu_sum;
  logic        alu_c_in, alu_c_out;
  logic [2:0]  alu_oper;
  logic        res_valid, res_ready;
  logic [31:0] res_sum;
  logic        res_c_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign {alu_c_out, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_c_in};

  alu_byte_seq #(.MAX_BYTES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_oper  (req_oper),
    .req_c_in  (req_c_in),
    .req_len   (req_len),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_c_in  (alu_c_in),
    .alu_oper  (alu_oper),
    .alu_sum   (alu_sum),
    .alu_c_out (alu_c_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_c_out (res_c_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wide add restricted to the low len+1 bytes; the carry is the bit just above them.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic ci,
                       input logic [1:0] ln, output logic [31:0] s, output logic c);
    longint unsigned m, t;
    int w;
    w = 8 * (int'(ln) + 1);
    m = (64'd1 << w) - 64'd1;
    t = (longint'(a) & m) + (longint'(b) & m) + longint'(ci);
    s = 32'(t & m);
    c = t[w];
  endtask

  // Entered and left on a falling edge.
  task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                     input logic ci, input logic [1:0] ln, input int hold);
    logic [31:0] es;
    logic        ec;
    int          n;
    model(a, b, ci, ln, es, ec);
    req_a = a; req_b = b; req_oper = op; req_c_in = ci; req_len = ln; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom; req_c_in = ~ci; req_oper = 3'(~op);
    req_len = 2'($urandom);
    chk("run_c_in0", 64'(alu_c_in), 64'(ci));
    chk("run_oper", 64'(alu_oper), 64'(op));
    chk("run_a0", 64'(alu_a), 64'(a[7:0]));
    chk("run_ready", 64'(req_ready), 64'd0);
    n = 0;
    while (!res_valid && n < 10) begin @(negedge clk); n++; end
    chk("latency", 64'(n), 64'(int'(ln) + 1));
    chk("res_sum", 64'(res_sum), 64'(es));
    chk("res_c_out", 64'(res_c_out), 64'(ec));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_sum", 64'(res_sum), 64'(es));
      chk("hold_c_out", 64'(res_c_out), 64'(ec));
      chk("hold_ready", 64'(req_ready), 64'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("post_valid", 64'(res_valid), 64'd0);
    chk("post_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] ra, rb, es0, es1;
    logic        ec0, ec1, seen;
    logic [31:0] b2b_a [2];
    int          acc_t [2];
    int          nacc, nres;

    rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
    req_a = '0; req_b = '0; req_oper = '0; req_c_in = 1'b0; req_len = '0;
    #2;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_sum", 64'(res_sum), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);

    txn(32'h0000_00FF, 32'h0000_0001, 3'd0, 1'b0, 2'd3, 0);
    chk("sc1_sum", 64'(res_sum), 64'h100);
    txn(32'hFFFF_FFFF, 32'h0000_0001, 3'd5, 1'b0, 2'd3, 0);
    chk("sc2_c_out", 64'(res_c_out), 64'd1);
    txn(32'h1234_56F0, 32'h0000_0010, 3'd2, 1'b1, 2'd0, 0);
    chk("sc3_sum", 64'(res_sum), 64'h1);
    txn(32'h8899_AABB, 32'h7766_5544, 3'd7, 1'b1, 2'd2, 5);

    // Reset pulse while byte 2 is on the ALU.
    req_a = 32'hA1B2_C3D4; req_b = 32'h0101_0101; req_oper = 3'd3; req_c_in = 1'b1;
    req_len = 2'd3; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_byte2", 64'(alu_a), 64'hB2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_alu_a", 64'(alu_a), 64'd0);
    chk("rst_mid_alu_b", 64'(alu_b), 64'd0);
    chk("rst_mid_alu_cin", 64'(alu_c_in), 64'd0);
    chk("rst_mid_alu_oper", 64'(alu_oper), 64'd0);
    chk("rst_mid_sum", 64'(res_sum), 64'd0);
    chk("rst_mid_c_out", 64'(res_c_out), 64'd0);
    chk("rst_mid_valid", 64'(res_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (res_valid) seen = 1'b1; end
    chk("rst_no_result", 64'(seen), 64'd0);
    txn(32'h0000_FFFF, 32'h0000_0001, 3'd1, 1'b0, 2'd1, 1);

    // Back-to-back with res_ready high; req_a changes right after the first accept.
    b2b_a[0] = 32'h00FF_FFFF; b2b_a[1] = 32'h0000_80FF;
    model(b2b_a[0], 32'h0000_0001, 1'b0, 2'd2, es0, ec0);
    model(b2b_a[1], 32'h0000_8001, 1'b1, 2'd1, es1, ec1);
    res_ready = 1'b1;
    req_a = b2b_a[0]; req_b = 32'h0000_0001; req_c_in = 1'b0; req_len = 2'd2;
    req_oper = 3'd4; req_valid = 1'b1;
    nacc = 0; nres = 0; acc_t[0] = 0; acc_t[1] = 0;
    for (int cyc = 0; cyc < 60 && nres < 2; cyc++) begin
      logic acc;
      acc = req_valid && req_ready;
      if (res_valid) begin
        chk("b2b_sum", 64'(res_sum), 64'(nres == 0 ? es0 : es1));
        chk("b2b_c_out", 64'(res_c_out), 64'(nres == 0 ? ec0 : ec1));
        nres++;
      end
      if (acc && nacc < 2) begin acc_t[nacc] = cyc; nacc++; end
      @(negedge clk);
      if (acc && nacc == 1) begin
        req_a = b2b_a[1]; req_b = 32'h0000_8001; req_c_in = 1'b1; req_len = 2'd1;
      end else if (acc && nacc == 2) begin
        req_valid = 1'b0; req_a = $urandom; req_len = 2'd3;
      end
    end
    res_ready = 1'b0;
    chk("b2b_results", 64'(nres), 64'd2);
    chk("b2b_spacing", 64'(acc_t[1] - acc_t[0]), 64'd5);

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? ~ra : 32'($urandom);
      txn(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom), 2'($urandom),
          int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_byte_seq.md
ALU_BYTE_SEQ -- requirements
Module: alu_byte_seq

Interface
REQ-001 The block SHALL have parameter MAX_BYTES, default 4, meaning the maximum operand width in bytes (fixed at 4 for this release).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports req_valid (in, 1) and req_ready (out, 1), the request handshake.
REQ-005 The block SHALL have ports req_a (in, 32) and req_b (in, 32), the operands, with byte 0 = bits [7:0].
REQ-006 The block SHALL have ports req_oper (in, 3), the ALU operation code passed through unchanged, and req_c_in (in, 1), the initial carry.
REQ-007 The block SHALL have port req_len (in, 2), the byte count minus one (0 = 1 byte ... 3 = 4 bytes).
REQ-008 The block SHALL have ports alu_a (out, 8), alu_b (out, 8), alu_c_in (out, 1) and alu_oper (out, 3), driving the downstream 8-bit ALU.
REQ-009 The block SHALL have ports alu_sum (in, 8) and alu_c_out (in, 1), the combinational ALU result for the current drive.
REQ-010 The block SHALL have ports res_valid (out, 1) and res_ready (in, 1), the result handshake.
REQ-011 The block SHALL have ports res_sum (out, 32), the assembled result, and res_c_out (out, 1), the final carry.

Function
REQ-012 The block SHALL implement states IDLE, RUN and DONE.
REQ-013 In IDLE, the block SHALL drive req_ready=1, and all alu_* outputs and res_valid SHALL be 0.
REQ-014 On a cycle with req_valid and req_ready both high, the block SHALL latch req_a, req_b, req_oper, req_c_in and req_len, clear the byte index k to 0, clear res_sum, and enter RUN.
REQ-015 In RUN, the block SHALL drive req_ready=0, alu_a=a[8k+7:8k], alu_b=b[8k+7:8k] and alu_oper=latched oper.
REQ-016 In RUN, alu_c_in SHALL be the latched req_c_in when k=0; otherwise it SHALL be the alu_c_out captured at byte k-1.
REQ-017 At each RUN clock edge, the block SHALL write alu_sum into res_sum[8k+7:8k], capture alu_c_out, and increment k.
REQ-018 When k equals the latched len at an edge, the block SHALL perform the capture of REQ-017 and then enter DONE. RUN therefore lasts len+1 cycles.
REQ-019 Result bytes above the latched len SHALL read 0.
REQ-020 res_c_out SHALL be the alu_c_out captured for the final byte.
REQ-021 In DONE, the block SHALL drive res_valid=1, and res_sum and res_c_out SHALL be stable and held until res_ready=1.
REQ-022 A cycle in DONE with res_ready=1 SHALL complete the transfer, and the block SHALL return to IDLE.
REQ-023 The minimum spacing between request acceptances SHALL be len+3 cycles: accept, RUN, DONE, and one IDLE bubble.
REQ-024 Latency from the accept edge to the first res_valid=1 cycle SHALL be len+1 edges.
REQ-025 Changes to req_* after acceptance SHALL have no effect on the operation in flight.
REQ-026 req_valid asserted outside IDLE SHALL be ignored and SHALL not be lost.
  - The requester holds req_valid until it sees req_ready.
REQ-027 res_ready asserted outside DONE SHALL be ignored.
REQ-028 The block SHALL NOT interpret oper. The carry chain is applied identically for every oper value.

Reset
REQ-029 Assertion of rst_n=0 SHALL immediately force IDLE, k=0, res_sum=0, res_c_out=0, res_valid=0, all alu_* outputs=0 and the captured carry=0, regardless of the current state.
REQ-030 Reset asserted mid-RUN or in DONE SHALL discard the operation, and no result SHALL be presented.
REQ-031 After rst_n deasserts, req_ready SHALL be 1 from the first rising edge.

Verification
REQ-032 The bench SHALL model the ALU as add: {c_out,sum} = a+b+c_in.
REQ-033 Scenario: 4-byte add of a=0x0000_00FF, b=0x0000_0001, c_in=0, len=3 -> res_sum=0x0000_0100, res_c_out=0, with res_valid at edge 4 after accept.
REQ-034 Scenario: a=0xFFFF_FFFF, b=0x0000_0001, c_in=0, len=3 -> res_sum=0x0000_0000 and res_c_out=1 (carry propagates across all bytes).
REQ-035 Scenario: len=0, a=0x1234_56F0, b=0x0000_0010, c_in=1 -> res_sum=0x0000_0001 and res_c_out=1. Only one RUN cycle occurs, and bytes 1-3 read 0.
REQ-036 Scenario: res_ready held low for 5 cycles after res_valid -> res_valid, res_sum and res_c_out are held unchanged, and req_ready=0 throughout.
REQ-037 Scenario: rst_n pulsed low during RUN byte 2 -> all outputs are 0 immediately, no res_valid ever appears, and the next request completes correctly.
REQ-038 Scenario: req_a changed one cycle after accept, with two back-to-back requests and res_ready tied high -> results match the latched operands, and the accept spacing is len+3 cycles.
